// File: rtl/addsub_pkg.sv
// Shared types and constants for the two-requester add/subtract controller.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/addsub_alu.sv
// Combinational WIDTH-bit add/subtract, modulo 2^WIDTH; zero latency, no flow control.
module addsub_alu
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] result
);

    // Carry/borrow fall off the top; subtraction wraps as two's complement.
    assign result = (op == OP_SUB) ? (a - b) : (a + b);

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one add/sub ALU between two requesters; result valid 2 cycles after accept.
// Result is held in DONE until out_ready; requesters see ready=0 whenever the controller is not IDLE.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_id,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic             deliver;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             id_q;
    logic [WIDTH-1:0] alu_result;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = ID_REQ0;
        if (req0_valid && req1_valid)
            grant_id = ~last_grant;
        else if (req1_valid)
            grant_id = ID_REQ1;
    end

    assign accept     = (state == IDLE) && grant_vld;
    assign deliver    = (state == DONE) && out_ready;
    assign req0_ready = accept && (grant_id == ID_REQ0);
    assign req1_ready = accept && (grant_id == ID_REQ1);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= ID_REQ1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            id_q       <= ID_REQ0;
            out_result <= '0;
            out_id     <= ID_REQ0;
            ops_done   <= '0;
        end else begin
            if (accept) begin
                a_q        <= (grant_id == ID_REQ1) ? req1_a  : req0_a;
                b_q        <= (grant_id == ID_REQ1) ? req1_b  : req0_b;
                op_q       <= (grant_id == ID_REQ1) ? req1_op : req0_op;
                id_q       <= grant_id;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                out_result <= alu_result;
                out_id     <= id_q;
            end
            if (deliver)
                ops_done <= ops_done + CNT_W'(1);
        end
    end

    addsub_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

endmodule
